// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: four-source round-robin arbiter that drives the s1/s0
// selects of a downstream 4-to-1 mux and holds them while the consumer samples.
// A grant is released by ack, by the granted request dropping, or by a
// watchdog after TIMEOUT cycles; priority then rotates past the released source.
// Optional feature macro: MUX_SEL_ARBITER_LOCK_EN (adds a lock input that
// defers ack-release and freezes the watchdog while asserted).
// Parameter constraints: 1 <= TIMEOUT <= 255 and 2**CW > TIMEOUT.

module mux_sel_arbiter #(
  parameter int TIMEOUT = 15,
  parameter int CW      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       ack,
`ifdef MUX_SEL_ARBITER_LOCK_EN
  input  logic       lock,
`endif
  output logic       s1,
  output logic       s0,
  output logic [3:0] gnt,
  output logic       valid,
  output logic       tmo
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state;
  logic [1:0]    sel;        // registered select pair, drives s1/s0
  logic [1:0]    ptr;        // highest-priority source for the next pick
  logic [CW-1:0] cnt;        // cycles the current grant has been held

  // Lock qualifier: constant zero when the feature is compiled out.
  logic hold;
`ifdef MUX_SEL_ARBITER_LOCK_EN
  assign hold = lock;
`else
  assign hold = 1'b0;
`endif

  // First set bit of r, scanning p, p+1, ... modulo 4. Iterating from the
  // farthest offset down lets the nearest requester overwrite the result.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] i);
    onehot = 4'b0001 << i;
  endfunction

  // Release decode and the candidate picks for both states.
  logic       ack_rel;
  logic       drop_rel;
  logic       expire;
  logic       release_now;
  logic [1:0] ptr_next;
  logic [3:0] masked_req;
  logic [1:0] next_pick;
  logic [1:0] idle_pick;

  // NOTE: every always_comb output gets a value on every path (defaults first),
  // otherwise synthesis infers a latch to remember the old value.
  always_comb begin
    ack_rel     = 1'b0;
    drop_rel    = 1'b0;
    expire      = 1'b0;
    release_now = 1'b0;
    if (state == GRANT) begin
      ack_rel  = ack & ~hold;
      drop_rel = ~req[sel];
      // Watchdog fires only when nothing else is releasing; a frozen
      // watchdog (lock held) never fires.
      expire   = (cnt == CNT_LAST) & ~ack & req[sel] & ~hold;
      release_now = ack_rel | drop_rel | expire;
    end
    ptr_next   = sel + 2'd1;
    // The released source sits out this edge's re-pick, so a timed-out
    // requester cannot immediately win again.
    masked_req = req & ~onehot(sel);
    next_pick  = rr_pick(masked_req, ptr_next);
    idle_pick  = rr_pick(req, ptr);
  end

  // Arbiter FSM: state, pointer, watchdog and all registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel   <= 2'd0;
      ptr   <= 2'd0;
      cnt   <= '0;
      gnt   <= 4'b0000;
      valid <= 1'b0;
      tmo   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tmo <= 1'b0;
          if (req != 4'b0000) begin
            state <= GRANT;
            sel   <= idle_pick;
            gnt   <= onehot(idle_pick);
            valid <= 1'b1;
            cnt   <= '0;
          end
        end
        GRANT: begin
          tmo <= expire;
          if (release_now) begin
            ptr <= ptr_next;
            if (masked_req != 4'b0000) begin
              // Back-to-back hand-over: valid stays high, no bubble.
              sel <= next_pick;
              gnt <= onehot(next_pick);
              cnt <= '0;
            end else begin
              // Selects keep their last value; only gnt/valid drop.
              state <= IDLE;
              gnt   <= 4'b0000;
              valid <= 1'b0;
            end
          end else if (!hold) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 4'b0000;
          valid <= 1'b0;
          tmo   <= 1'b0;
        end
      endcase
    end
  end

  assign s1 = sel[1];
  assign s0 = sel[0];

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb_mux_sel_arbiter: directed stimulus with hand-computed expectations plus a
// behavioural model (grant owner, hold-time in cycles, priority pointer) that
// is compared against every DUT output on every falling clock edge.
// Optional feature macro: MUX_SEL_ARBITER_LOCK_EN (enables the lock test).

module tb_mux_sel_arbiter;

  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       ack = 1'b0;
  logic       lock = 1'b0;
  logic       s1, s0, valid, tmo;
  logic [3:0] gnt;

  int vectors = 0;
  int miscompares = 0;

  mux_sel_arbiter #(.TIMEOUT(TIMEOUT), .CW(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .ack   (ack),
`ifdef MUX_SEL_ARBITER_LOCK_EN
    .lock  (lock),
`endif
    .s1    (s1),
    .s0    (s0),
    .gnt   (gnt),
    .valid (valid),
    .tmo   (tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_busy = 1'b0;   // some source currently owns the mux
  int m_sel  = 0;      // owner (or last owner while idle)
  int m_ptr  = 0;      // where the round-robin scan starts
  int m_held = 0;      // cycles the current owner has been shown valid
  bit m_tmo  = 1'b0;

  function automatic int first_from(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int  w, n_sel, n_ptr, n_held;
    bit  n_busy, n_tmo, lk, acked, dropped, timed;
    logic [3:0] rest;
    if (rst) begin
      m_busy <= 1'b0; m_sel <= 0; m_ptr <= 0; m_held <= 0; m_tmo <= 1'b0;
    end else begin
      n_busy = m_busy; n_sel = m_sel; n_ptr = m_ptr; n_held = m_held; n_tmo = 1'b0;
`ifdef MUX_SEL_ARBITER_LOCK_EN
      lk = lock;
`else
      lk = 1'b0;
`endif
      if (!m_busy) begin
        w = first_from(req, m_ptr);
        if (w >= 0) begin n_busy = 1'b1; n_sel = w; n_held = 1; end
      end else begin
        acked   = ack && !lk;
        dropped = !req[m_sel];
        timed   = (m_held == TIMEOUT) && !ack && req[m_sel] && !lk;
        if (acked || dropped || timed) begin
          n_tmo = timed;
          n_ptr = (m_sel + 1) % 4;
          rest  = req;
          rest[m_sel] = 1'b0;
          w = first_from(rest, n_ptr);
          if (w >= 0) begin n_sel = w; n_held = 1; end
          else n_busy = 1'b0;
        end else if (!lk) begin
          n_held = m_held + 1;
        end
      end
      m_busy <= n_busy; m_sel <= n_sel; m_ptr <= n_ptr; m_held <= n_held; m_tmo <= n_tmo;
    end
  end

  // Cycle-by-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    check("model_valid", 32'(valid), 32'(m_busy));
    check("model_gnt", 32'(gnt), m_busy ? (32'd1 << m_sel) : 32'd0);
    check("model_sel", 32'({s1, s0}), 32'(m_sel));
    check("model_tmo", 32'(tmo), 32'(m_tmo));
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    req = 4'b0000; ack = 1'b0; lock = 1'b0;
    #1 rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] rot_gnt [5];
    rot_gnt[0] = 4'b0001; rot_gnt[1] = 4'b0010; rot_gnt[2] = 4'b0100;
    rot_gnt[3] = 4'b1000; rot_gnt[4] = 4'b0001;

    // Reset values.
    do_reset();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_sel", 32'({s1, s0}), 32'h0);
    check("rst_tmo", 32'(tmo), 32'h0);

    // Single request: one-cycle latency, ack releases to idle.
    req = 4'b0001;
    cyc(1);
    check("single_gnt", 32'(gnt), 32'b0001);
    check("single_valid", 32'(valid), 32'h1);
    check("single_sel", 32'({s1, s0}), 32'h0);
    ack = 1'b1; req = 4'b0000;
    cyc(1);
    check("single_rel_valid", 32'(valid), 32'h0);
    check("single_rel_gnt", 32'(gnt), 32'h0);
    ack = 1'b0;

    // Full rotation, back-to-back with ack every cycle.
    do_reset();
    req = 4'b1111; ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check("rot_gnt", 32'(gnt), 32'(rot_gnt[i]));
      check("rot_valid", 32'(valid), 32'h1);
      check("rot_sel", 32'({s1, s0}), 32'(i % 4));
    end
    ack = 1'b0; req = 4'b0000;
    cyc(2);

    // Watchdog on a lone requester: 15 valid cycles, tmo with valid low, re-grant.
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < TIMEOUT; i++) begin
      cyc(1);
      check("wd_hold_valid", 32'(valid), 32'h1);
      check("wd_hold_tmo", 32'(tmo), 32'h0);
    end
    cyc(1);
    check("wd_tmo", 32'(tmo), 32'h1);
    check("wd_tmo_valid", 32'(valid), 32'h0);
    cyc(1);
    check("wd_regrant_gnt", 32'(gnt), 32'b0100);
    check("wd_regrant_tmo", 32'(tmo), 32'h0);
    req = 4'b0000;
    cyc(2);

    // Watchdog with a competing requester: timed-out source is skipped.
    do_reset();
    req = 4'b0011;
    cyc(1);
    check("wd2_first", 32'(gnt), 32'b0001);
    cyc(TIMEOUT);
    check("wd2_tmo", 32'(tmo), 32'h1);
    check("wd2_next", 32'(gnt), 32'b0010);
    check("wd2_valid", 32'(valid), 32'h1);

    // Ack on the expiry edge wins: no tmo.
    do_reset();
    req = 4'b0110;
    cyc(1);
    check("ackwd_first", 32'(gnt), 32'b0010);
    cyc(TIMEOUT - 1);
    ack = 1'b1;
    cyc(1);
    check("ackwd_tmo", 32'(tmo), 32'h0);
    check("ackwd_gnt", 32'(gnt), 32'b0100);
    ack = 1'b0; req = 4'b0000;
    cyc(2);

    // Asynchronous reset mid-grant.
    do_reset();
    req = 4'b1000;
    cyc(1);
    check("ar_gnt", 32'(gnt), 32'b1000);
    check("ar_sel", 32'({s1, s0}), 32'h3);
    #2 rst = 1'b1;
    #1;
    check("ar_async_gnt", 32'(gnt), 32'h0);
    check("ar_async_valid", 32'(valid), 32'h0);
    check("ar_async_sel", 32'({s1, s0}), 32'h0);
    cyc(1);
    rst = 1'b0; req = 4'b1010;
    cyc(1);
    check("ar_after_gnt", 32'(gnt), 32'b0010);

    // Granted request drops without ack: hand over to input 3.
    do_reset();
    req = 4'b0010;
    cyc(1);
    check("drop_first", 32'(gnt), 32'b0010);
    req = 4'b1000;
    cyc(1);
    check("drop_gnt", 32'(gnt), 32'b1000);
    check("drop_sel", 32'({s1, s0}), 32'h3);
    check("drop_tmo", 32'(tmo), 32'h0);
    check("drop_valid", 32'(valid), 32'h1);

    // Ack while idle is ignored.
    do_reset();
    ack = 1'b1;
    cyc(2);
    check("idle_ack_valid", 32'(valid), 32'h0);
    ack = 1'b0;

`ifdef MUX_SEL_ARBITER_LOCK_EN
    // Lock defers ack-release and freezes the watchdog.
    do_reset();
    req = 4'b0001;
    cyc(1);
    lock = 1'b1; ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      check("lock_gnt", 32'(gnt), 32'b0001);
      check("lock_tmo", 32'(tmo), 32'h0);
    end
    lock = 1'b0;
    cyc(1);
    check("lock_rel_valid", 32'(valid), 32'h0);
    ack = 1'b0; req = 4'b0000;
    cyc(1);
`endif

    // Mixed directed sequence checked by the model only.
    do_reset();
    for (int i = 0; i < 24; i++) begin
      req = 4'((i * 7 + 3) % 16);
      ack = (i % 3) == 1;
      cyc(1);
    end
    req = 4'b0000; ack = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
